// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared sizing helpers for the pipelined carry-lookahead adder
//
// Purpose : stage-count derivation and legality check for the WIDTH/BLK split.
// Contents: n_stages(width, blk) -> number of pipeline stages (= latency)
//           blk_ok(width, blk)   -> 1 when blk divides width and 1 <= blk <= width
package cla_pkg;

    function automatic int n_stages(input int width, input int blk);
        // Guard keeps elaboration alive long enough for blk_ok to report a bad BLK.
        return (blk > 0) ? (width / blk) : 1;
    endfunction

    function automatic bit blk_ok(input int width, input int blk);
        return (blk >= 1) && (blk <= width) && ((width % blk) == 0);
    endfunction

endpackage

// File: rtl/cla_block.sv
// rtl/cla_block.sv - combinational BLK-bit carry-lookahead block
//
// Purpose : one pipeline stage worth of addition, carries formed by lookahead
//           from per-bit generate/propagate terms.
// Ports   : a, b     in  BLK  operand slices
//           ci       in  1    carry into bit 0 of the block
//           s        out BLK  sum slice
//           co       out 1    carry out of the block's top bit
//           c_msb_in out 1    carry into the block's top bit (for overflow)
module cla_block #(
    parameter int BLK = 8
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           ci,
    output logic [BLK-1:0] s,
    output logic           co,
    output logic           c_msb_in
);

    logic [BLK-1:0] p;
    logic [BLK-1:0] g;
    logic [BLK:0]   c;

    assign p = a ^ b;
    assign g = a & b;

    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]ci, expanded per bit rather
    // than rippled, so every carry is a flat sum of products.
    always_comb begin
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < BLK; i++) begin
            logic t;
            logic pp;
            t  = g[i];
            pp = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                t  = t | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = t | (pp & ci);
        end
    end

    assign s        = p ^ c[BLK-1:0];
    assign co       = c[BLK];
    assign c_msb_in = c[BLK-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - pipelined carry-lookahead adder/subtractor with valid/ready
//
// Purpose : WIDTH-bit add/subtract, one BLK-bit block resolved per stage,
//           inter-block carry registered; one result per clock, latency NSTG.
// Ports   : clk, rst (sync, active high)
//           in_valid/in_ready, a, b, ci, sub   operand beat
//           out_valid/out_ready, s, co, ovf    result beat
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BLK   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int NSTG = n_stages(WIDTH, BLK);

    if (!blk_ok(WIDTH, BLK)) begin : g_bad_blk
        $error("cla_pipe_adder: BLK must divide WIDTH and lie in 1..WIDTH");
    end

    // Index k holds what stage k consumes; index NSTG is the output register.
    // a_in doubles as the skew register: each stage shifts its operand right by
    // BLK and inserts its sum slice at the top, so after NSTG stages the word
    // is exactly the result.  b_in rotates so the next slice is always at the
    // bottom; the last stage needs no b register.
    logic [WIDTH-1:0] a_in [NSTG+1];
    logic [WIDTH-1:0] b_in [NSTG];
    logic             c_in [NSTG+1];
    logic             v_in [NSTG+1];
    logic             cm_w [NSTG];
    logic             co_w [NSTG];
    logic             adv;
    logic             ovf_r;

    assign adv      = !v_in[NSTG] || out_ready;
    assign in_ready = adv;

    assign a_in[0] = a;
    assign b_in[0] = b ^ {WIDTH{sub}};
    assign c_in[0] = ci ^ sub;
    assign v_in[0] = in_valid;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        logic [BLK-1:0]   bs;
        logic [WIDTH-1:0] a_nxt;
        logic [WIDTH-1:0] a_r;
        logic             c_r;
        logic             v_r;

        cla_block #(.BLK(BLK)) u_blk (
            .a        (a_in[k][BLK-1:0]),
            .b        (b_in[k][BLK-1:0]),
            .ci       (c_in[k]),
            .s        (bs),
            .co       (co_w[k]),
            .c_msb_in (cm_w[k])
        );

        if (BLK == WIDTH) begin : g_one
            assign a_nxt = bs;
        end else begin : g_shift
            assign a_nxt = {bs, a_in[k][WIDTH-1:BLK]};
        end

        // Bubbles shift along with real beats; only v_r marks them.
        always_ff @(posedge clk) begin
            if (rst) begin
                a_r <= '0;
                c_r <= 1'b0;
                v_r <= 1'b0;
            end else if (adv) begin
                a_r <= a_nxt;
                c_r <= co_w[k];
                v_r <= v_in[k];
            end
        end

        assign a_in[k+1] = a_r;
        assign c_in[k+1] = c_r;
        assign v_in[k+1] = v_r;

        if (k < NSTG - 1) begin : g_b
            logic [WIDTH-1:0] b_r;

            always_ff @(posedge clk) begin
                if (rst) begin
                    b_r <= '0;
                end else if (adv) begin
                    b_r <= {b_in[k][BLK-1:0], b_in[k][WIDTH-1:BLK]};
                end
            end

            assign b_in[k+1] = b_r;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (adv) begin
            ovf_r <= cm_w[NSTG-1] ^ co_w[NSTG-1];
        end
    end

    assign s         = a_in[NSTG];
    assign co        = c_in[NSTG];
    assign ovf       = ovf_r;
    assign out_valid = v_in[NSTG];

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb/tb_cla_pipe_adder.sv - self-checking bench for cla_pipe_adder (32/8, 16/16, 24/1)
module tb_cla_pipe_adder;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic        sub;
        logic [31:0] s;
        logic        co;
        logic        ovf;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        iv_d   [3];
    logic        ci_d   [3];
    logic        sub_d  [3];
    logic        ordy_d [3];
    logic [31:0] a_d    [3];
    logic [31:0] b_d    [3];
    logic        ir_o   [3];
    logic        ov_o   [3];
    logic        co_o   [3];
    logic        ovf_o  [3];
    logic [31:0] s0;
    logic [15:0] s1;
    logic [23:0] s2;

    int          n_pass;
    int          n_total;
    logic [33:0] exp_q [3][$];
    int          out_cnt   [3];
    logic        hold_pend [3];
    logic [33:0] hold_val  [3];
    vec_t        vt [7];

    cla_pipe_adder #(.WIDTH(32), .BLK(8)) dut (
        .clk(clk), .rst(rst), .in_valid(iv_d[0]), .in_ready(ir_o[0]),
        .a(a_d[0]), .b(b_d[0]), .ci(ci_d[0]), .sub(sub_d[0]),
        .out_valid(ov_o[0]), .out_ready(ordy_d[0]), .s(s0), .co(co_o[0]), .ovf(ovf_o[0])
    );

    cla_pipe_adder #(.WIDTH(16), .BLK(16)) dut_w16 (
        .clk(clk), .rst(rst), .in_valid(iv_d[1]), .in_ready(ir_o[1]),
        .a(a_d[1][15:0]), .b(b_d[1][15:0]), .ci(ci_d[1]), .sub(sub_d[1]),
        .out_valid(ov_o[1]), .out_ready(ordy_d[1]), .s(s1), .co(co_o[1]), .ovf(ovf_o[1])
    );

    cla_pipe_adder #(.WIDTH(24), .BLK(1)) dut_w24 (
        .clk(clk), .rst(rst), .in_valid(iv_d[2]), .in_ready(ir_o[2]),
        .a(a_d[2][23:0]), .b(b_d[2][23:0]), .ci(ci_d[2]), .sub(sub_d[2]),
        .out_valid(ov_o[2]), .out_ready(ordy_d[2]), .s(s2), .co(co_o[2]), .ovf(ovf_o[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int width_of(input int idx);
        return (idx == 0) ? 32 : ((idx == 1) ? 16 : 24);
    endfunction

    function automatic logic [33:0] get_res(input int idx);
        case (idx)
            0:       return {ovf_o[0], co_o[0], s0};
            1:       return {ovf_o[1], co_o[1], 16'h0, s1};
            default: return {ovf_o[2], co_o[2], 8'h0, s2};
        endcase
    endfunction

    // Golden model: plain integer arithmetic on (w+1)-bit unsigned and
    // signed interpretations of a, the conditioned b and the carry-in.
    function automatic logic [33:0] model(input int w, input logic [31:0] aa,
                                          input logic [31:0] bb, input logic cc,
                                          input logic su);
        longint mask, am, bm, cin, tot, half, sa, sb, st;
        logic [31:0] sr;
        logic        cr, vr;
        mask = (longint'(1) << w) - 1;
        am   = longint'(aa) & mask;
        bm   = longint'(su ? ~bb : bb) & mask;
        cin  = longint'(cc ^ su);
        tot  = am + bm + cin;
        sr   = 32'(tot & mask);
        cr   = ((tot >> w) & 1) != 0;
        half = longint'(1) << (w - 1);
        sa   = (am >= half) ? am - (longint'(1) << w) : am;
        sb   = (bm >= half) ? bm - (longint'(1) << w) : bm;
        st   = sa + sb + cin;
        vr   = (st >= half) || (st < -half);
        return {vr, cr, sr};
    endfunction

    task automatic check(input bit ok, input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // One clock of traffic on DUT idx: drive at negedge, judge handshake and
    // outputs just after, effect lands on the following posedge.
    task automatic step(input int idx, input logic iv, input logic [31:0] aa,
                        input logic [31:0] bb, input logic cc, input logic su,
                        input logic ordy, output logic fin, output logic fout);
        logic [33:0] cur;
        logic [33:0] e;
        @(negedge clk);
        iv_d[idx]   = iv;
        a_d[idx]    = aa;
        b_d[idx]    = bb;
        ci_d[idx]   = cc;
        sub_d[idx]  = su;
        ordy_d[idx] = ordy;
        #1;
        cur = get_res(idx);
        check(ir_o[idx] == (!ov_o[idx] || ordy), "in_ready_rule", 64'(ir_o[idx]),
              64'(!ov_o[idx] || ordy));
        if (hold_pend[idx]) begin
            check(ov_o[idx] && (cur == hold_val[idx]), "output_hold",
                  {29'h0, ov_o[idx], cur}, {29'h0, 1'b1, hold_val[idx]});
        end
        fin  = iv && ir_o[idx];
        fout = ov_o[idx] && ordy;
        if (fout) begin
            check(exp_q[idx].size() != 0, "unexpected_out", 64'(cur), 64'h0);
            if (exp_q[idx].size() != 0) begin
                e = exp_q[idx].pop_front();
                check(cur == e, "result", 64'(cur), 64'(e));
            end
            out_cnt[idx]++;
        end
        hold_pend[idx] = ov_o[idx] && !ordy;
        hold_val[idx]  = cur;
        if (fin) exp_q[idx].push_back(model(width_of(idx), aa, bb, cc, su));
    endtask

    // Single beat on the 32/8 instance with an otherwise empty pipe:
    // out_valid must rise only after the fourth edge and last one cycle.
    task automatic single(input vec_t v, input string tag);
        logic       fin, fout;
        logic [4:0] pat;
        step(0, 1'b1, v.a, v.b, v.ci, v.sub, 1'b1, fin, fout);
        check(fin, {tag, "_accept"}, 64'(fin), 64'h1);
        pat = '0;
        for (int i = 0; i < 5; i++) begin
            step(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, fin, fout);
            pat[4-i] = ov_o[0];
            if (i == 3) begin
                check(get_res(0) == {v.ovf, v.co, v.s}, tag, 64'(get_res(0)),
                      64'({v.ovf, v.co, v.s}));
            end
        end
        check(pat == 5'b00010, {tag, "_latency"}, 64'(pat), 64'h2);
    endtask

    task automatic random_run(input int idx, input int nbeats);
        logic        fin, fout;
        logic [31:0] ra, rb;
        int          acc, base, cyc;
        acc  = 0;
        base = out_cnt[idx];
        cyc  = 0;
        while (acc < nbeats && cyc < 30000) begin
            ra = $urandom();
            rb = $urandom();
            step(idx, $urandom_range(3) != 0, ra, rb, 1'($urandom_range(1)),
                 1'($urandom_range(1)), $urandom_range(9) < 7, fin, fout);
            if (fin) acc++;
            cyc++;
        end
        check(acc == nbeats, "random_accept_budget", 64'(acc), 64'(nbeats));
        cyc = 0;
        while (exp_q[idx].size() != 0 && cyc < 200) begin
            step(idx, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, fin, fout);
            cyc++;
        end
        check(exp_q[idx].size() == 0, "random_drain", 64'(exp_q[idx].size()), 64'h0);
        check(out_cnt[idx] - base == nbeats, "random_count", 64'(out_cnt[idx] - base),
              64'(nbeats));
    endtask

    initial begin
        logic fin, fout;
        int   sent, base, stale, c;

        n_pass  = 0;
        n_total = 0;
        vt[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vt[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vt[2] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        vt[3] = '{32'h00000010, 32'h00000001, 1'b1, 1'b1, 32'h0000000E, 1'b1, 1'b0};
        vt[4] = '{32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0};
        vt[5] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        vt[6] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};

        for (int i = 0; i < 3; i++) begin
            iv_d[i] = 1'b0; ci_d[i] = 1'b0; sub_d[i] = 1'b0; ordy_d[i] = 1'b1;
            a_d[i] = '0; b_d[i] = '0; out_cnt[i] = 0; hold_pend[i] = 1'b0;
            hold_val[i] = '0;
        end

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check(ov_o[0] == 1'b0, "reset_out_valid", 64'(ov_o[0]), 64'h0);
        check(ir_o[0] == 1'b1, "reset_in_ready", 64'(ir_o[0]), 64'h1);
        check(get_res(0) == 34'h0, "reset_result", 64'(get_res(0)), 64'h0);
        check(!ov_o[1] && !ov_o[2], "reset_out_valid_other", {ov_o[1], ov_o[2]}, 64'h0);

        for (int i = 0; i < 7; i++) single(vt[i], $sformatf("vec%0d", i));

        // Backpressure: 8 back-to-back beats, out_ready low for cycles 5..7.
        sent = 0;
        base = out_cnt[0];
        c    = 0;
        while ((out_cnt[0] - base < 8) && c < 60) begin
            step(0, sent < 8, $urandom(), $urandom(), 1'($urandom_range(1)),
                 1'($urandom_range(1)), !(c >= 5 && c < 8), fin, fout);
            if (c >= 5 && c < 8) begin
                check(ir_o[0] == 1'b0, "stall_in_ready", 64'(ir_o[0]), 64'h0);
            end
            if (fin) sent++;
            c++;
        end
        check(sent == 8, "bp_sent", 64'(sent), 64'h8);
        check(out_cnt[0] - base == 8, "bp_count", 64'(out_cnt[0] - base), 64'h8);
        check(exp_q[0].size() == 0, "bp_queue_empty", 64'(exp_q[0].size()), 64'h0);

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) begin
            step(0, 1'b1, $urandom(), $urandom(), 1'b0, 1'b0, 1'b1, fin, fout);
        end
        @(negedge clk);
        rst     = 1'b1;
        iv_d[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check(ov_o[0] == 1'b0, "rst_mid_out_valid", 64'(ov_o[0]), 64'h0);
        exp_q[0].delete();
        hold_pend[0] = 1'b0;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, fin, fout);
            if (ov_o[0]) stale++;
        end
        check(stale == 0, "rst_mid_no_stale", 64'(stale), 64'h0);
        single(vt[4], "post_reset");

        random_run(0, 2000);
        random_run(1, 2000);
        random_run(2, 2000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
